// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect/stall controls, instruction ROM port and IF/ID outputs.
// With FETCH_REDIRECT_COUNTER_EN defined the bus also carries oRedirectCount.
interface fetch_stage_if;
    logic        iStall;
    logic        iJump;
    logic [9:0]  iJumpAddr;
    logic        iBranchTaken;
    logic [9:0]  iBranchAddr;
    logic [9:0]  oIAddress;
    logic [15:0] iInstruction;
    logic [15:0] oInstruction;
    logic [9:0]  oPcPlus1;
    logic        oValid;
`ifdef FETCH_REDIRECT_COUNTER_EN
    logic [15:0] oRedirectCount;

    modport slave (
        input  iStall, iJump, iJumpAddr, iBranchTaken, iBranchAddr, iInstruction,
        output oIAddress, oInstruction, oPcPlus1, oValid, oRedirectCount
    );

    modport master (
        output iStall, iJump, iJumpAddr, iBranchTaken, iBranchAddr, iInstruction,
        input  oIAddress, oInstruction, oPcPlus1, oValid, oRedirectCount
    );
`else
    modport slave (
        input  iStall, iJump, iJumpAddr, iBranchTaken, iBranchAddr, iInstruction,
        output oIAddress, oInstruction, oPcPlus1, oValid
    );

    modport master (
        output iStall, iJump, iJumpAddr, iBranchTaken, iBranchAddr, iInstruction,
        input  oIAddress, oInstruction, oPcPlus1, oValid
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and FILL/RUN/FLUSH control FSM.
// Optional redirect counter enabled by defining FETCH_REDIRECT_COUNTER_EN.
module fetch_stage (
    input  logic          Clock,
    input  logic          Reset,
    fetch_stage_if.slave  bus
);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t      state;
    state_t      next_state;
    logic        redirect;
    logic [9:0]  target;
    logic [9:0]  pc;
    logic [15:0] instruction;
    logic [9:0]  pc_plus1;
    logic        valid;

    // Jump outranks branch; the target only matters when a redirect is requested.
    always_comb begin
        redirect = bus.iJump | bus.iBranchTaken;
        target   = bus.iJump ? bus.iJumpAddr : bus.iBranchAddr;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL, RUN, FLUSH: begin
                if (redirect)
                    next_state = FLUSH;
                else if (bus.iStall)
                    next_state = state;
                else
                    next_state = RUN;
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= FILL;
        else
            state <= next_state;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc          <= 10'd0;
            instruction <= 16'h0000;
            pc_plus1    <= 10'd0;
            valid       <= 1'b0;
        end else if (redirect) begin
            pc          <= target;
            instruction <= 16'h0000;
            pc_plus1    <= 10'd0;
            valid       <= 1'b0;
        end else if (!bus.iStall) begin
            pc          <= pc + 10'd1;
            instruction <= bus.iInstruction;
            pc_plus1    <= pc + 10'd1;
            valid       <= 1'b1;
        end
    end

    assign bus.oIAddress    = pc;
    assign bus.oInstruction = instruction;
    assign bus.oPcPlus1     = pc_plus1;
    assign bus.oValid       = valid;

`ifdef FETCH_REDIRECT_COUNTER_EN
    logic [15:0] redirect_count;

    always_ff @(posedge Clock) begin
        if (Reset)
            redirect_count <= 16'd0;
        else if (redirect && redirect_count != 16'hFFFF)
            redirect_count <= redirect_count + 16'd1;
    end

    assign bus.oRedirectCount = redirect_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random stall/redirect/reset
// traffic, compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

    fetch_stage dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    logic [15:0] rom [1024];
    assign bus.iInstruction = rom[bus.oIAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model state; mPc1Known is cleared on a bubble whose PC+1 is don't-care.
    int          mPc;
    logic [15:0] mInst;
    int          mPc1;
    logic        mValid;
    logic        mPc1Known;
    int          mCount;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          nPc;
        logic [15:0] nInst;
        int          nPc1;
        logic        nValid;
        logic        nKnown;
        int          nCount;
        nPc = mPc; nInst = mInst; nPc1 = mPc1; nValid = mValid; nKnown = mPc1Known; nCount = mCount;
        if (Reset) begin
            nPc = 0; nInst = 16'h0000; nPc1 = 0; nValid = 1'b0; nKnown = 1'b1; nCount = 0;
        end else if (bus.iJump || bus.iBranchTaken) begin
            nPc    = bus.iJump ? int'(bus.iJumpAddr) : int'(bus.iBranchAddr);
            nInst  = 16'h0000;
            nValid = 1'b0;
            nKnown = 1'b0;
            if (nCount < 65535) nCount = nCount + 1;
        end else if (!bus.iStall) begin
            nInst  = rom[mPc];
            nPc    = (mPc + 1) % 1024;
            nPc1   = nPc;
            nValid = 1'b1;
            nKnown = 1'b1;
        end
        @(posedge Clock);
        #1;
        mPc = nPc; mInst = nInst; mPc1 = nPc1; mValid = nValid; mPc1Known = nKnown; mCount = nCount;
        checkOutput("oIAddress", {6'd0, bus.oIAddress}, 16'(mPc));
        checkOutput("oInstruction", bus.oInstruction, mInst);
        checkOutput("oValid", {15'd0, bus.oValid}, {15'd0, mValid});
        if (mPc1Known)
            checkOutput("oPcPlus1", {6'd0, bus.oPcPlus1}, 16'(mPc1));
`ifdef FETCH_REDIRECT_COUNTER_EN
        checkOutput("oRedirectCount", bus.oRedirectCount, 16'(mCount));
`endif
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic jmp,
                                 input int jAddr, input logic br, input int bAddr);
        Reset            = rst;
        bus.iStall       = stall;
        bus.iJump        = jmp;
        bus.iJumpAddr    = 10'(jAddr);
        bus.iBranchTaken = br;
        bus.iBranchAddr  = 10'(bAddr);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mPc = 0; mInst = 16'h0000; mPc1 = 0; mValid = 1'b0; mPc1Known = 1'b0; mCount = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        Reset = 1'b1; bus.iStall = 1'b0; bus.iJump = 1'b0; bus.iBranchTaken = 1'b0;
        bus.iJumpAddr = 10'd0; bus.iBranchAddr = 10'd0;
        #2;

        // Reset, then free run up to PC=4
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_addr", {6'd0, bus.oIAddress}, 16'd0);
        checkOutput("reset_valid", {15'd0, bus.oValid}, 16'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("run_addr4", {6'd0, bus.oIAddress}, 16'd4);
        checkOutput("run_inst3", bus.oInstruction, rom[3]);

        // Stall three cycles at PC=4 (junk targets with requests low)
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 999, 0, 777);
        checkOutput("stall_addr", {6'd0, bus.oIAddress}, 16'd4);
        checkOutput("stall_inst", bus.oInstruction, rom[3]);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("resume_addr", {6'd0, bus.oIAddress}, 16'd5);

        // Jump to 200 from PC=7
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("pre_jump_addr", {6'd0, bus.oIAddress}, 16'd7);
        applyStimulus(0, 0, 1, 200, 0, 0);
        checkOutput("jump_addr", {6'd0, bus.oIAddress}, 16'd200);
        checkOutput("jump_bubble", {15'd0, bus.oValid}, 16'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("jump_inst", bus.oInstruction, rom[200]);
        checkOutput("jump_pc1", {6'd0, bus.oPcPlus1}, 16'd201);

        // Jump and branch together while stalled: jump wins, bubble inserted
        applyStimulus(0, 1, 1, 300, 1, 50);
        checkOutput("prio_addr", {6'd0, bus.oIAddress}, 16'd300);
        checkOutput("prio_bubble", {15'd0, bus.oValid}, 16'd0);
        applyStimulus(0, 0, 0, 0, 1, 50);
        checkOutput("branch_addr", {6'd0, bus.oIAddress}, 16'd50);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Wrap at 1023
        applyStimulus(0, 0, 1, 1023, 0, 0);
        checkOutput("wrap_addr1023", {6'd0, bus.oIAddress}, 16'd1023);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_addr0", {6'd0, bus.oIAddress}, 16'd0);
        checkOutput("wrap_inst", bus.oInstruction, rom[1023]);
        checkOutput("wrap_pc1", {6'd0, bus.oPcPlus1}, 16'd0);

        // Reset during FLUSH, then FILL behaviour
        applyStimulus(0, 0, 1, 600, 0, 0);
        applyStimulus(1, 1, 1, 100, 1, 100);
        checkOutput("flush_reset_addr", {6'd0, bus.oIAddress}, 16'd0);
        checkOutput("flush_reset_valid", {15'd0, bus.oValid}, 16'd0);
`ifdef FETCH_REDIRECT_COUNTER_EN
        checkOutput("flush_reset_count", bus.oRedirectCount, 16'd0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("fill_valid", {15'd0, bus.oValid}, 16'd1);
        checkOutput("fill_inst", bus.oInstruction, rom[0]);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 10), int'($urandom_range(0, 1023)),
                          ($urandom_range(0, 99) < 10), int'($urandom_range(0, 1023)));
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
